// File: rtl/shared_logic_unit_arbiter_pkg.sv
// shared_logic_pkg: op codes and default widths for the shared bitwise logic unit
package shared_logic_pkg;
    typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_PASS_A} op_t;
    localparam int DEFAULT_DATA_WIDTH = 16;
endpackage

// File: rtl/shared_logic_unit_arbiter_rr_picker.sv
// rr_picker: cyclic first-valid search starting just after the last granted index
module rr_picker #(
    parameter int N = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any_grant
);
    logic [IW-1:0] j;
    // Scan from lowest to highest priority so the nearest valid requester wins
    always_comb begin
        grant = '0;
        idx = '0;
        any_grant = 1'b0;
        j = '0;
        for (int k = N; k >= 1; k--) begin
            j = IW'((int'(last) + k) % N);
            if (en && req[j]) begin
                grant = '0;
                grant[j] = 1'b1;
                idx = j;
                any_grant = 1'b1;
            end
        end
    end
endmodule

// File: rtl/shared_logic_unit_arbiter.sv
// shared_logic_unit_arbiter: round-robin sharing of one registered bitwise logic unit
module shared_logic_unit_arbiter
    import shared_logic_pkg::*;
#(
    parameter int REQ_CNT = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ID_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REQ_CNT-1:0]            req_valid,
    output logic [REQ_CNT-1:0]            req_ready,
    input  logic [REQ_CNT*2-1:0]          req_op,
    input  logic [REQ_CNT*DATA_WIDTH-1:0] req_a,
    input  logic [REQ_CNT*DATA_WIDTH-1:0] req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [7:0]                    busy_cnt
);
    logic                  out_full;
    logic                  can_accept;
    logic                  xfer;
    logic [ID_WIDTH-1:0]   last_grant;
    logic [ID_WIDTH-1:0]   g;
    logic [REQ_CNT-1:0]    grant;
    op_t                   op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] f;
    int                    gi;

    assign can_accept = !out_full || rsp_ready;
    assign req_ready = grant;
    assign rsp_valid = out_full;

    rr_picker #(.N(REQ_CNT), .IW(ID_WIDTH)) u_picker (
        .req(req_valid),
        .last(last_grant),
        .en(can_accept && !rst),
        .grant(grant),
        .idx(g),
        .any_grant(xfer)
    );

    always_comb begin
        gi = int'(g);
        op = op_t'(req_op[2*gi +: 2]);
        a = req_a[DATA_WIDTH*gi +: DATA_WIDTH];
        b = req_b[DATA_WIDTH*gi +: DATA_WIDTH];
        f = op == OP_AND ? a & b : op == OP_OR ? a | b : op == OP_XOR ? a ^ b : a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_full <= 1'b0;
            rsp_data <= '0;
            rsp_id <= '0;
            busy_cnt <= '0;
            last_grant <= ID_WIDTH'(REQ_CNT - 1);
        end else begin
            if (xfer) begin
                rsp_data <= f;
                rsp_id <= g;
                out_full <= 1'b1;
                last_grant <= g;
            end else if (rsp_ready) begin
                out_full <= 1'b0;
            end
            if (|req_valid && !can_accept && busy_cnt != 8'hFF)
                busy_cnt <= busy_cnt + 8'd1;
        end
    end
endmodule

// File: doc/shared_logic_unit_arbiter.md
Name: shared_logic_unit_arbiter

Overview:
- Shares one registered 16-bit bitwise logic unit (AND/OR/XOR/PASS_A) between REQ_CNT requesters.
- Each requester presents operands through a valid/ready handshake.
- The block round-robin arbitrates among requesters, executes one operation per cycle and returns the tagged result through a single valid/ready response port.
- Sits between local producers and the shared bitwise datapath, replacing per-requester gate instances.

Parameters:
- REQ_CNT, 4, number of requesters (2..8).
- DATA_WIDTH, 16, operand/result width.
- ID_WIDTH, 2, requester index width; must satisfy 2**ID_WIDTH >= REQ_CNT.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  REQ_CNT  per-requester request valid.
- req_ready  output  REQ_CNT  per-requester accept; at most one bit high per cycle.
- req_op  input  REQ_CNT*2  per-requester op code (op_t), requester i at [2i+1:2i].
- req_a  input  REQ_CNT*DATA_WIDTH  operand A, requester i at [DATA_WIDTH*(i+1)-1:DATA_WIDTH*i].
- req_b  input  REQ_CNT*DATA_WIDTH  operand B, same packing as req_a.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  downstream accepts result.
- rsp_data  output  DATA_WIDTH  result.
- rsp_id  output  ID_WIDTH  index of the requester that issued the op.
- busy_cnt  output  8  saturating count of cycles with any req_valid high but no grant (stall statistic).

Behaviour:
- Reset (rst=1 at a clock edge), regardless of in-flight state:
  - rsp_valid=0, rsp_data=0, rsp_id=0, busy_cnt=0.
  - last_grant = REQ_CNT-1, so requester 0 has first priority.
  - A pending result is discarded.
  - req_ready=0 while rst is high.
- Output stage: one result register (out_full).
  - can_accept = !out_full || rsp_ready. Combinational; rsp_ready passes straight to req_ready.
- Arbitration, combinational:
  - When can_accept=1, grant the first requester with req_valid=1, searching cyclically from last_grant+1.
  - req_ready[g]=1 for that requester only. All other req_ready bits are 0.
  - When can_accept=0, all req_ready bits are 0.
- Transfer: occurs when req_valid[g] && req_ready[g]. On that edge:
  - rsp_data <= f(op, a, b).
  - rsp_id <= g.
  - out_full <= 1.
  - last_grant <= g.
- Latency: exactly 1 cycle from request transfer to rsp_valid.
- Throughput: 1 op/cycle while rsp_ready=1.
- Op codes (op_t): 2'b00 AND, 2'b01 OR, 2'b10 XOR, 2'b11 PASS_A (result = a). All results are DATA_WIDTH bits; no sign extension or carry.
- Response handshake:
  - rsp_valid = out_full.
  - When rsp_valid && rsp_ready with no new transfer, out_full <= 0.
  - A simultaneous drain and new transfer keeps out_full=1 and loads the new result (no bubble).
  - While rsp_valid=1 && rsp_ready=0, rsp_data and rsp_id hold stable.
- Fairness: a requester that was just granted has lowest priority next cycle. With all REQ_CNT requesters continuously valid, grants follow 0,1,2,3,0,...
- last_grant is unchanged in cycles with no transfer.
- busy_cnt increments when (|req_valid) && !can_accept. It saturates at 8'hFF and never wraps.
- Requester obligation: once req_valid is asserted, req_op/req_a/req_b hold stable until accepted. The block is not required to detect violations.
- Idle (no req_valid): no state change except output draining.

Decomposition:
- Package shared_logic_pkg: typedef enum logic [1:0] op_t {OP_AND, OP_OR, OP_XOR, OP_PASS_A}; constant DEFAULT_DATA_WIDTH=16.
- Sub-module rr_picker (parameter N):
  - Inputs: req vector, last index, enable.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational; instantiated once.
- The op evaluation is an inline case on op_t, not a separate module.

Test Plan:
- Reset mid-operation: out_full=1 with rsp_ready=0, assert rst one cycle -> next cycle rsp_valid=0, busy_cnt=0; first grant after reset goes to requester 0 when all four are valid.
- Single requester: req1 valid, op=AND, a=16'hF0F0, b=16'h3C3C, rsp_ready=1 -> req_ready=4'b0010 same cycle; next cycle rsp_valid=1, rsp_data=16'h3030, rsp_id=1.
- Round-robin: all four valid continuously, rsp_ready=1, ops AND/OR/XOR/PASS_A with a=16'h00FF, b=16'h0F0F -> grants 0,1,2,3,0 on consecutive cycles; results 16'h000F, 16'h0FFF, 16'h0FF0, 16'h00FF.
- Backpressure: rsp_ready=0 for 5 cycles with req2 valid after one result is held -> rsp_data/rsp_id stable, req_ready=0, busy_cnt increases by 5. Raise rsp_ready -> old result drains and req2 is accepted on the same edge (no bubble).
- Saturation: hold rsp_ready=0 with a request pending for 300 cycles -> busy_cnt reaches 8'hFF and stays at 8'hFF.
- Idle last_grant retention: grant req3, idle 3 cycles, then req0 and req3 valid together -> req0 is granted first.
